// File: rtl/grant_sequencer.sv
// Turns one arbiter grant into a locked multi-beat transfer on a shared valid/ready bus.
// The owner and length are latched at grant time; grant is ignored until the transfer retires.
module grant_sequencer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        grant,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    input  logic [LEN_W-1:0]  req_len2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic              bus_ready,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic [1:0]        bus_src,
    output logic [2:0]        data_pop,
    output logic [2:0]        ack,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [1:0]         owner_q;
    logic [LEN_W-1:0]   remaining_q;
    logic               err_q;
    logic               valid_q;
    logic               busy_q;
    logic [2:0]         ack_q;

    logic               grant_multi;
    logic [1:0]         grant_idx;
    logic [LEN_W-1:0]   grant_len;
    logic [2:0]         owner_onehot;
    logic               beat_fire;

    // Any two bits set means the arbiter broke its one-hot promise.
    always_comb begin
        grant_multi = (grant[0] & grant[1]) | (grant[0] & grant[2]) | (grant[1] & grant[2]);
        grant_idx   = 2'd0;
        if (grant[1]) begin
            grant_idx = 2'd1;
        end else if (grant[2]) begin
            grant_idx = 2'd2;
        end
        case (grant_idx)
            2'd1:    grant_len = req_len1;
            2'd2:    grant_len = req_len2;
            default: grant_len = req_len0;
        endcase
    end

    always_comb begin
        owner_onehot = 3'b000;
        case (owner_q)
            2'd0:    owner_onehot = 3'b001;
            2'd1:    owner_onehot = 3'b010;
            2'd2:    owner_onehot = 3'b100;
            default: owner_onehot = 3'b000;
        endcase
    end

    assign beat_fire = valid_q & bus_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 3'b000;
                    if (grant_multi) begin
                        err_q <= 1'b1;
                    end else if (grant != 3'b000) begin
                        owner_q     <= grant_idx;
                        remaining_q <= grant_len;
                        state_q     <= XFER;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        // Leave on the last beat so the counter never wraps.
                        if (remaining_q == '0) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            ack_q   <= owner_onehot;
                        end else begin
                            remaining_q <= remaining_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ack_q   <= 3'b000;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ack_q   <= 3'b000;
                end
            endcase
        end
    end

    // Data path is a live mux so the owner's head can change beat to beat.
    always_comb begin
        bus_data = '0;
        if (valid_q) begin
            case (owner_q)
                2'd1:    bus_data = req_data1;
                2'd2:    bus_data = req_data2;
                default: bus_data = req_data0;
            endcase
        end
    end

    assign bus_valid = valid_q;
    assign bus_src   = busy_q ? owner_q : 2'd0;
    assign data_pop  = beat_fire ? owner_onehot : 3'b000;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_grant_sequencer.sv
// Randomised plus directed bench for grant_sequencer; a transaction-level model feeds
// expectation queues that an independent negedge monitor drains against the DUT.
module tb_grant_sequencer;

    logic       clk = 1'b0;
    logic       r_reset = 1'b1;
    logic [2:0] r_grant = 3'b000;
    logic [3:0] r_len [3];
    logic [7:0] r_data [3];
    logic       r_ready = 1'b0;

    logic       bus_valid;
    logic [7:0] bus_data;
    logic [1:0] bus_src;
    logic [2:0] data_pop;
    logic [2:0] ack;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    grant_sequencer #(.DATA_W(8), .LEN_W(4)) dut (
        .clk       (clk),
        .reset     (r_reset),
        .grant     (r_grant),
        .req_len0  (r_len[0]),
        .req_len1  (r_len[1]),
        .req_len2  (r_len[2]),
        .req_data0 (r_data[0]),
        .req_data1 (r_data[1]),
        .req_data2 (r_data[2]),
        .bus_ready (r_ready),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_src   (bus_src),
        .data_pop  (data_pop),
        .ack       (ack),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic       busy;
        logic       err;
        logic       valid;
        logic [1:0] src;
        logic [7:0] data;
        logic [2:0] pop;
        logic [2:0] ack;
        bit         chk_sd;
    } stat_t;

    stat_t      stat_q [$];
    logic [9:0] beat_q [$];
    logic [2:0] ack_q  [$];

    int errors = 0;
    int checks = 0;

    // Transaction model: phase 0 = free, 1 = moving beats, 2 = acknowledging.
    int m_phase = 0;
    int m_owner = 0;
    int m_left  = 0;
    bit m_err   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input bit rst, input logic [2:0] g, input bit rdy,
                        input int l0, input int l1, input int l2);
        stat_t s;
        int    idx;
        @(posedge clk);
        // Advance the model using what the DUT just sampled.
        if (r_reset) begin
            m_phase = 0;
            m_err   = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: if (r_grant != 3'b000) begin
                       if ($countones(r_grant) > 1) begin
                           m_err = 1;
                       end else begin
                           idx = 0;
                           for (int i = 0; i < 3; i++) if (r_grant[i]) idx = i;
                           m_owner = idx;
                           m_left  = int'(r_len[idx]) + 1;
                           m_phase = 1;
                       end
                   end
                1: if (r_ready) begin
                       m_left--;
                       if (m_left == 0) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
        #1;
        r_reset = rst;
        r_grant = g;
        r_ready = rdy;
        r_len[0] = 4'(l0);
        r_len[1] = 4'(l1);
        r_len[2] = 4'(l2);
        for (int i = 0; i < 3; i++) r_data[i] = 8'($urandom);

        s.busy   = (m_phase != 0);
        s.err    = m_err;
        s.valid  = (m_phase == 1);
        s.src    = (m_phase == 1) ? 2'(m_owner) : 2'd0;
        s.data   = (m_phase == 1) ? r_data[m_owner] : 8'h00;
        s.pop    = (m_phase == 1 && rdy) ? 3'(1 << m_owner) : 3'b000;
        s.ack    = (m_phase == 2) ? 3'(1 << m_owner) : 3'b000;
        s.chk_sd = (m_phase != 2);
        stat_q.push_back(s);
        if (m_phase == 1 && rdy) beat_q.push_back({2'(m_owner), r_data[m_owner]});
        if (m_phase == 2) ack_q.push_back(3'(1 << m_owner));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 3'b000, rdy, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        stat_t      s;
        logic [9:0] b;
        logic [2:0] a;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            check("busy", 32'(busy), 32'(s.busy));
            check("err", 32'(err), 32'(s.err));
            check("bus_valid", 32'(bus_valid), 32'(s.valid));
            check("data_pop", 32'(data_pop), 32'(s.pop));
            check("ack", 32'(ack), 32'(s.ack));
            if (s.chk_sd) begin
                check("bus_src", 32'(bus_src), 32'(s.src));
                check("bus_data", 32'(bus_data), 32'(s.data));
            end
            if (bus_valid === 1'b1 && r_ready === 1'b1) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 32'd1, 32'd0);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_src_data", 32'({bus_src, bus_data}), 32'(b));
                end
            end
            if (ack !== 3'b000) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    check("ack_owner", 32'(ack), 32'(a));
                end
            end
        end
    end

    initial begin
        logic [2:0] g;
        int         r;
        for (int i = 0; i < 3; i++) begin
            r_len[i]  = 4'd0;
            r_data[i] = 8'h00;
        end

        step(1, 3'b000, 1, 0, 0, 0);
        step(1, 3'b000, 1, 0, 0, 0);
        // Requester 1, three beats with ready held.
        step(0, 3'b010, 1, 0, 2, 0);
        idle(6, 1);
        // Single beat with ready low for two cycles.
        step(0, 3'b001, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0, 0);
        step(0, 3'b000, 1, 0, 0, 0);
        idle(3, 1);
        // Grant and length changes during a transfer are ignored.
        step(0, 3'b001, 1, 3, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 3'b100, 1, 15, 0, 1);
        idle(6, 1);
        // Multi-hot grant sets sticky err; a later grant still works.
        step(0, 3'b011, 1, 5, 5, 5);
        idle(2, 1);
        step(0, 3'b100, 1, 0, 0, 2);
        idle(6, 1);
        // Reset mid-transfer after three beats.
        step(0, 3'b001, 1, 7, 0, 0);
        idle(3, 1);
        step(1, 3'b000, 1, 0, 0, 0);
        idle(3, 1);
        // Maximum length: sixteen beats.
        step(0, 3'b100, 1, 0, 0, 15);
        idle(20, 1);

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 9) g = 3'b000;
            else if (r < 14) g = 3'(1 << $urandom_range(0, 2));
            else if ($urandom_range(0, 3) == 0) g = 3'($urandom);
            else g = 3'b000;
            step(($urandom_range(0, 199) == 0), g, ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)));
        end
        idle(24, 1);
        @(negedge clk);
        @(negedge clk);
        check("stat_q_drained", 32'(stat_q.size()), 32'd0);
        check("beat_q_drained", 32'(beat_q.size()), 32'd0);
        check("ack_q_drained", 32'(ack_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grant_sequencer.md
# grant_sequencer

Downstream stage of the 3-way request arbiter: consumes the arbiter's `grant[2:0]` and turns one grant into a complete, locked multi-beat transfer on a shared output bus. It captures the granted owner and transfer length, muxes that owner's data onto a valid/ready bus, pops the owner's source once per accepted beat, and pulses a per-requester acknowledge on completion. While a transfer is in flight the grant input is ignored, which makes the arbiter's grant "sticky" for the whole transfer.

## Interface
- `DATA_W`, 8, bus and per-requester data width
- `LEN_W`, 4, length field width; a transfer is `len+1` beats (1..2^LEN_W)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `grant`  in  3  arbiter grant; one-hot or zero; bit i = requester i
- `req_len0`/`req_len1`/`req_len2`  in  LEN_W each  beats-minus-one for requester 0/1/2
- `req_data0`/`req_data1`/`req_data2`  in  DATA_W each  current head data of requester 0/1/2
- `bus_ready`  in  1  downstream accepts the beat this cycle
- `bus_valid`  out  1  beat on `bus_data` is valid
- `bus_data`  out  DATA_W  owner's data, `req_dataN` muxed live (not registered)
- `bus_src`  out  2  owner index 0..2; 0 when idle
- `data_pop`  out  3  one-hot, combinational: `bus_valid & bus_ready` routed to the owner bit
- `ack`  out  3  one-cycle pulse on the owner bit when its last beat has been accepted
- `busy`  out  1  high whenever state != IDLE
- `err`  out  1  sticky: multi-hot grant seen in IDLE; cleared only by reset

## Operation
- States: IDLE, XFER, DONE. Registers: state, owner (2 b), remaining (LEN_W b), err.
- IDLE: sample `grant` each edge.
  - Zero -> stay IDLE.
  - Exactly one bit set -> owner = bit index, remaining = `req_lenN` of that owner, go XFER.
  - More than one bit set -> set err, stay IDLE, no transfer.
- XFER: `bus_valid`=1, `bus_src`=owner, `bus_data`=`req_data[owner]`.
  - On `bus_valid & bus_ready`: `data_pop[owner]`=1 in that same cycle. If remaining==0, go DONE; else remaining-1.
  - Without ready: hold state and remaining; `bus_data` follows the owner's live input.
  - `grant` and all `req_len*` are ignored. Length is captured only at the IDLE->XFER edge.
- DONE: `ack[owner]`=1 for exactly one cycle, `bus_valid`=0, then IDLE.
- Idle outputs: `bus_valid`=0, `bus_data`=0, `bus_src`=0, `data_pop`=0, `ack`=0, `busy`=0.
- Reset (synchronous): state=IDLE, owner=0, remaining=0, err=0. All outputs take their idle values from the next cycle.
  - Reset during XFER or DONE aborts the transfer. No ack is issued for it.
  - If reset and `grant` are both asserted at an edge, reset wins.
- Decrement never underflows: the transition out of XFER happens at remaining==0.

## Timing
- Grant sampled in IDLE at edge k -> `busy`=1 and first `bus_valid` in cycle k+1.
- Ready held high: N=len+1 beats occupy N cycles of XFER, then 1 DONE cycle with ack, then 1 IDLE cycle. The earliest next grant is sampled at the end of that IDLE cycle, so back-to-back transfers cost N+2 cycles.
- Every cycle with ready low stretches the transfer by exactly 1 cycle.
- `data_pop` is zero-latency relative to the handshake. Requester head data must update by the next cycle.
- `ack` asserts in the cycle after the final handshake.

## Test plan
- Reset, then grant=3'b010, len1=2, ready=1 -> bus_src=1, bus_valid for 3 cycles, data_pop=3'b010 each cycle, ack=3'b010 one cycle later, busy low after 5 cycles total.
- grant=3'b001, len0=0, ready toggling 0,0,1 -> single beat accepted on the 3rd XFER cycle, exactly one data_pop, then ack=3'b001.
- During a requester-0 transfer, change grant to 3'b100 and len0 to 15 -> transfer completes with the originally captured length; requester 2 starts only after DONE+IDLE.
- grant=3'b011 in IDLE -> err=1, busy stays 0, no bus_valid. A later valid grant=3'b100 still completes normally, and err stays 1 until reset.
- Reset asserted mid-XFER (len=7, after 3 beats) -> next cycle bus_valid=0, busy=0, no ack pulse, err=0.
- len=2^LEN_W-1 (15), ready=1 -> exactly 16 beats and 16 pops, remaining wraps to nothing, single ack.
